// File: rtl/aes_inv_sbox_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_sbox_engine_if
// Brief    : Input/output valid-ready bus of the InvSubBytes engine.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_inv_sbox_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_inv_sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_sbox_engine
// Brief    : Sequential AES InvSubBytes over LANES shared inverse S-box lanes.
//            Define AES_INV_SBOX_PIPE_EN to register every lane output.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_sbox_engine #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_sbox_engine_if.slave bus
);
    localparam int C_PASSES = 16 / LANES;
`ifdef AES_INV_SBOX_PIPE_EN
    localparam int C_BUSY_CYC = C_PASSES + 1;
`else
    localparam int C_BUSY_CYC = C_PASSES;
`endif
    localparam int              C_CW   = (C_BUSY_CYC > 1) ? $clog2(C_BUSY_CYC) : 1;
    localparam int              C_LSH  = $clog2(LANES);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(C_BUSY_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_st;
    state_t          w_st_nxt;
    logic [127:0]    r_blk;
    logic [C_CW-1:0] r_pass;
    logic [3:0]      w_issue_grp;
    logic [3:0]      w_wb_grp;
    logic            w_wb_en;
    logic [7:0]      w_lane_res [LANES];
    logic [3:0]      w_wb_idx   [LANES];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the field inverse and maps 0 to 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] a;
        a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

    assign w_issue_grp = 4'(r_pass);
`ifdef AES_INV_SBOX_PIPE_EN
    // results land one cycle after issue; first BUSY cycle has nothing to write
    assign w_wb_grp = 4'(r_pass - 1'b1);
    assign w_wb_en  = (r_pass != '0);
`else
    assign w_wb_grp = w_issue_grp;
    assign w_wb_en  = 1'b1;
`endif

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            logic [3:0] w_in_idx;
            logic [7:0] w_in_byte;
            assign w_in_idx    = 4'((int'(w_issue_grp) << C_LSH) + j);
            assign w_in_byte   = r_blk[{w_in_idx, 3'b000} +: 8];
            assign w_wb_idx[j] = 4'((int'(w_wb_grp) << C_LSH) + j);
`ifdef AES_INV_SBOX_PIPE_EN
            logic [7:0] r_lane_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_lane_q <= '0;
                end else if (r_st == S_BUSY) begin
                    r_lane_q <= inv_sbox(w_in_byte);
                end
            end
            assign w_lane_res[j] = r_lane_q;
`else
            assign w_lane_res[j] = inv_sbox(w_in_byte);
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_st <= S_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt      = r_st;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        case (r_st)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) w_st_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (r_pass == C_LAST) w_st_nxt = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_st_nxt = S_IDLE;
            end
            default: begin
                w_st_nxt = S_IDLE;
                bus.busy = 1'b0;
            end
        endcase
    end

    assign bus.out_data = r_blk;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blk  <= '0;
            r_pass <= '0;
        end else begin
            case (r_st)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_blk  <= bus.in_data;
                        r_pass <= '0;
                    end
                end
                S_BUSY: begin
                    r_pass <= (r_pass == C_LAST) ? '0 : r_pass + 1'b1;
                    if (w_wb_en) begin
                        for (int j = 0; j < LANES; j++) begin
                            r_blk[{w_wb_idx[j], 3'b000} +: 8] <= w_lane_res[j];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_sbox_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_sbox_engine
// Brief    : Directed-vector bench for the InvSubBytes engine (LANES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_inv_sbox_engine;
    localparam int LANES = 4;
`ifdef AES_INV_SBOX_PIPE_EN
    localparam int C_LAT = 16 / LANES + 1;
`else
    localparam int C_LAT = 16 / LANES;
`endif
    localparam int C_GAP = C_LAT + 2;

    // FIPS-197 forward S-box; the inverse must undo it for every byte
    localparam logic [7:0] C_SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam logic [127:0] C_DIR_IN  = 128'h0000_0000_0000_0000_0000_52ed_0016_7c63;
    localparam logic [127:0] C_DIR_EXP = 128'h5252_5252_5252_5252_5252_4853_52ff_0100;
    localparam logic [127:0] C_SEQ_IN  = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
    localparam logic [127:0] C_SEQ_EXP = 128'hfbd7_f381_9ea3_40bf_38a5_3630_d56a_0952;
    localparam logic [127:0] C_SB0_IN  = 128'h76ab_d7fe_2b67_0130_c56f_6bf2_7b77_7c63;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    aes_inv_sbox_engine_if bus ();

    aes_inv_sbox_engine #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // called on a negedge; returns on the negedge right after the accepting edge
    task automatic send(input logic [127:0] d);
        int guard;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 128'(bus.in_ready), 128'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) chk("out_timeout", 128'(bus.out_valid), 128'd1);
    endtask

    task automatic take(output logic [127:0] d);
        d             = bus.out_data;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] dexp);
        int           lat;
        logic [127:0] res;
        send(din);
        wait_out(lat);
        chk({tag, "_latency"}, 128'(lat), 128'(C_LAT));
        take(res);
        chk({tag, "_data"}, res, dexp);
    endtask

    initial begin
        logic [127:0] din;
        logic [127:0] dexp;
        logic [127:0] res;
        logic [127:0] blk [3];
        logic [127:0] bexp [3];
        logic [127:0] bres [3];
        int           acc_cyc [3];
        int           lat;
        int           cyc;
        int           nacc;
        int           nout;
        logic         saw_valid;

        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  128'(bus.in_ready),  128'd1);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_busy",      128'(bus.busy),      128'd0);
        chk("rst_out_data",  bus.out_data,        128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_block("directed", C_DIR_IN, C_DIR_EXP);
        run_block("seq", C_SEQ_IN, C_SEQ_EXP);

        // every byte value appears once, as Sbox(x); the engine must give back x
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) begin
                din[8*k +: 8]  = C_SBOX[16*b + k];
                dexp[8*k +: 8] = 8'(16*b + k);
            end
            run_block($sformatf("sweep%0d", b), din, dexp);
        end

        send(C_SEQ_IN);
        chk("bp_busy", 128'(bus.busy), 128'd1);
        wait_out(lat);
        chk("bp_latency", 128'(lat), 128'(C_LAT));
        bus.in_valid = 1'b1;
        bus.in_data  = C_DIR_IN;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_data",  bus.out_data,         C_SEQ_EXP);
            chk("bp_in_ready",   128'(bus.in_ready),   128'd0);
            chk("bp_out_valid",  128'(bus.out_valid),  128'd1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_valid", 128'(bus.out_valid), 128'd0);
        chk("bp_release_ready", 128'(bus.in_ready),  128'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(lat);
        chk("bp_second_latency", 128'(lat), 128'(C_LAT));
        take(res);
        chk("bp_second_data", res, C_DIR_EXP);

        bus.in_valid = 1'b1;
        bus.in_data  = C_SEQ_IN;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_in_ready",  128'(bus.in_ready),  128'd1);
        chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("mid_rst_busy",      128'(bus.busy),      128'd0);
        saw_valid = 1'b0;
        repeat (C_LAT + 2) begin
            @(negedge clk);
            saw_valid = saw_valid | bus.out_valid;
        end
        chk("mid_rst_no_output", 128'(saw_valid), 128'd0);
        run_block("after_rst", C_DIR_IN, C_DIR_EXP);

        blk[0]  = C_DIR_IN;  bexp[0] = C_DIR_EXP;
        blk[1]  = C_SEQ_IN;  bexp[1] = C_SEQ_EXP;
        blk[2]  = C_SB0_IN;  bexp[2] = C_SEQ_IN;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = 0;
            bres[i]    = '0;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        cyc  = 0;
        nacc = 0;
        nout = 0;
        while (nout < 3 && cyc < 200) begin
            if (nacc < 3) bus.in_data = blk[nacc];
            else          bus.in_valid = 1'b0;
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            if (bus.out_valid) begin
                bres[nout] = bus.out_data;
                nout++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("b2b_count", 128'(nout), 128'd3);
        chk("b2b_gap01", 128'(acc_cyc[1] - acc_cyc[0]), 128'(C_GAP));
        chk("b2b_gap12", 128'(acc_cyc[2] - acc_cyc[1]), 128'(C_GAP));
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_data%0d", i), bres[i], bexp[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
